pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 26 ++
 rtl/pc_ras.sv | 62 ++++++
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants, next-PC select encoding and log2 helper for the PC sequencer.
package pc_seq_pkg;

  localparam logic [31:0] DefaultResetVector = 32'h0000_0000;
  localparam logic [31:0] DefaultExcVector   = 32'h0000_0180;

  typedef enum logic [2:0] {
    SelSeq,
    SelBranch,
    SelJump,
    SelJumpReg,
    SelReturn,
    SelExc,
    SelHold
  } next_sel_e;

  // Smallest n with 2**n >= value; exact for the power-of-two STEP values.
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_top;
  logic [CntW-1:0]  r_count;
  logic [PtrW-1:0]  w_top_inc;
  logic [PtrW-1:0]  w_top_dec;
  logic             w_replace;

  assign w_top_inc = (r_top == LastIdx) ? '0 : r_top + PtrW'(1);
  assign w_top_dec = (r_top == '0) ? LastIdx : r_top - PtrW'(1);
  // Simultaneous pop and push keeps the depth and just rewrites the top slot.
  assign w_replace = i_push && i_pop && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_replace) begin
      r_top <= r_top;
    end else if (i_push) begin
      r_top <= w_top_inc;
      if (r_count != FullCnt) r_count <= r_count + CntW'(1);
    end else if (i_pop && (r_count != '0)) begin
      r_top   <= w_top_dec;
      r_count <= r_count - CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (w_replace) begin
        r_mem[r_top] <= i_push_data;
      end else if (i_push) begin
        r_mem[w_top_inc] <= i_push_data;
      end
    end
  end

  assign o_top   = r_mem[r_top];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FullCnt);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC selection, return-address stack,
// alignment fault and redirect flush.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DefaultResetVector),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DefaultExcVector),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_offset,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_target,
  input  logic             i_jump_reg,
  input  logic [WIDTH-1:0] i_reg_target,
  input  logic             i_call,
  input  logic             i_return,
  input  logic             i_exception,
  output logic [WIDTH-1:0] o_pc_result,
  output logic [WIDTH-1:0] o_pc_add_result,
  output logic             o_flush,
  output logic             o_misaligned,
  output logic             o_ras_err,
  output logic             o_ras_empty,
  output logic             o_ras_full,
  output logic [WIDTH-1:0] o_advance_count
);

  localparam int unsigned      StepShift = log2_ceil(STEP);
  localparam logic [WIDTH-1:0] StepInc   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] AlignMask = WIDTH'(STEP - 1);

  logic [WIDTH-1:0] r_pc;
  logic             r_flush;
  logic             r_misaligned;
  logic             r_ras_err;
  logic [WIDTH-1:0] r_advance_count;

  next_sel_e        w_sel;
  logic [WIDTH-1:0] w_pc_add;
  logic [WIDTH-1:0] w_branch_target;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_redirect;
  logic             w_misaligned;
  logic             w_ras_err_set;
  logic             w_advance;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_full;

  assign w_pc_add        = r_pc + StepInc;
  assign w_branch_target = w_pc_add + (i_branch_offset << StepShift);

  always_comb begin
    w_sel         = SelSeq;
    w_ras_err_set = 1'b0;
    if (i_exception) begin
      w_sel = SelExc;
    end else if (i_stall) begin
      w_sel = SelHold;
    end else if (i_return) begin
      // An empty stack degrades the return to a plain sequential step.
      if (w_ras_empty) w_ras_err_set = 1'b1;
      else             w_sel         = SelReturn;
    end else if (i_jump_reg) begin
      w_sel = SelJumpReg;
    end else if (i_jump) begin
      w_sel = SelJump;
    end else if (i_branch_taken) begin
      w_sel = SelBranch;
    end
  end

  always_comb begin
    w_target   = w_pc_add;
    w_redirect = 1'b1;
    case (w_sel)
      SelExc:     w_target = EXC_VECTOR;
      SelReturn:  w_target = w_ras_top;
      SelJumpReg: w_target = i_reg_target;
      SelJump:    w_target = i_jump_target;
      SelBranch:  w_target = w_branch_target;
      default:    w_redirect = 1'b0;
    endcase
  end

  assign w_misaligned = w_redirect && ((w_target & AlignMask) != '0);
  assign w_next_pc    = (w_sel == SelHold) ? r_pc :
                        w_redirect         ? (w_target & ~AlignMask) : w_pc_add;
  assign w_advance    = !i_stall || i_exception;

  assign w_pop  = (w_sel == SelReturn);
  assign w_push = i_call && ((w_sel == SelJump) || (w_sel == SelJumpReg) ||
                             (w_sel == SelReturn));

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_add),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (w_ras_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc            <= RESET_VECTOR;
      r_flush         <= 1'b0;
      r_misaligned    <= 1'b0;
      r_ras_err       <= 1'b0;
      r_advance_count <= '0;
    end else begin
      r_pc    <= w_next_pc;
      r_flush <= w_redirect;
      if (w_misaligned)  r_misaligned    <= 1'b1;
      if (w_ras_err_set) r_ras_err       <= 1'b1;
      if (w_advance)     r_advance_count <= r_advance_count + WIDTH'(1);
    end
  end

  assign o_pc_result     = r_pc;
  assign o_pc_add_result = w_pc_add;
  assign o_flush         = r_flush;
  assign o_misaligned    = r_misaligned;
  assign o_ras_err       = r_ras_err;
  assign o_ras_empty     = w_ras_empty;
  assign o_ras_full      = w_ras_full;
  assign o_advance_count = r_advance_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jump_reg, call, ret, exception;
  logic [31:0] branch_offset, jump_target, reg_target;
  logic [31:0] pc, pc_add, adv_cnt;
  logic        flush, misaligned, ras_err, ras_empty, ras_full;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = '0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH        (32),
    .STEP         (4),
    .RESET_VECTOR (32'h0),
    .EXC_VECTOR   (32'h180),
    .RAS_DEPTH    (4)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_offset (branch_offset),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_jump_reg      (jump_reg),
    .i_reg_target    (reg_target),
    .i_call          (call),
    .i_return        (ret),
    .i_exception     (exception),
    .o_pc_result     (pc),
    .o_pc_add_result (pc_add),
    .o_flush         (flush),
    .o_misaligned    (misaligned),
    .o_ras_err       (ras_err),
    .o_ras_empty     (ras_empty),
    .o_ras_full      (ras_full),
    .o_advance_count (adv_cnt)
  );

  task automatic idle();
    reset = 0; stall = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    call = 0; ret = 0; exception = 0;
    branch_offset = '0; jump_target = '0; reg_target = '0;
  endtask

  // One clock; the bench tracks the expected advance count alongside.
  task automatic step();
    @(posedge clk);
    if (reset) exp_cnt = '0;
    else if (!stall || exception) exp_cnt = exp_cnt + 1;
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    idle(); jump = 1; jump_target = addr; step(); idle();
  endtask

  task automatic test_reset();
    idle(); reset = 1; step(); step(); reset = 0;
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", pc); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush: got %b want 0", flush); end
    n_cmp++; if ({misaligned, ras_err} !== 2'b00) begin
      n_bad++; $display("FAIL rst_sticky: got %b%b want 00", misaligned, ras_err); end
    n_cmp++; if (adv_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", adv_cnt); end
    n_cmp++; if ({ras_empty, ras_full} !== 2'b10) begin
      n_bad++; $display("FAIL rst_ras: got %b%b want 10", ras_empty, ras_full); end
    n_cmp++; if (pc_add !== 32'h4) begin n_bad++; $display("FAIL rst_add: got %h want 4", pc_add); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (pc !== 32'(4 * i)) begin
        n_bad++; $display("FAIL free_pc%0d: got %h want %h", i, pc, 32'(4 * i)); end
    end
    n_cmp++; if (adv_cnt !== 32'd3) begin n_bad++; $display("FAIL free_cnt: got %0d want 3", adv_cnt); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL free_flush: got %b want 0", flush); end
  endtask

  task automatic test_branch();
    goto_pc(32'h100);
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL jmp_flush: got %b want 1", flush); end
    branch_taken = 1; branch_offset = 32'hFFFF_FFFE; step(); idle();
    n_cmp++; if (pc !== 32'h0FC) begin n_bad++; $display("FAIL br_pc: got %h want 0fc", pc); end
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL br_flush: got %b want 1", flush); end
    step();
    n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL br_next: got %h want 100", pc); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL br_flush2: got %b want 0", flush); end
    stall = 1; branch_taken = 1; branch_offset = 32'hFFFF_FFFE; step(); idle();
    n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL stall_pc: got %h want 100", pc); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL stall_flush: got %b want 0", flush); end
    n_cmp++; if (adv_cnt !== exp_cnt) begin
      n_bad++; $display("FAIL stall_cnt: got %0d want %0d", adv_cnt, exp_cnt); end
  endtask

  task automatic test_call_return();
    goto_pc(32'h40);
    jump = 1; jump_target = 32'h200; call = 1; step(); idle();
    n_cmp++; if (pc !== 32'h200) begin n_bad++; $display("FAIL call_pc: got %h want 200", pc); end
    n_cmp++; if (ras_empty !== 1'b0) begin n_bad++; $display("FAIL call_empty: got %b want 0", ras_empty); end
    step();
    ret = 1; step(); idle();
    n_cmp++; if (pc !== 32'h44) begin n_bad++; $display("FAIL ret_pc: got %h want 44", pc); end
    n_cmp++; if ({flush, ras_empty} !== 2'b11) begin
      n_bad++; $display("FAIL ret_flags: got %b%b want 11", flush, ras_empty); end
    ret = 1; step(); idle();
    n_cmp++; if (pc !== 32'h48) begin n_bad++; $display("FAIL ret_empty_pc: got %h want 48", pc); end
    n_cmp++; if ({ras_err, flush} !== 2'b10) begin
      n_bad++; $display("FAIL ret_empty_flags: got %b%b want 10", ras_err, flush); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};
    idle(); reset = 1; step(); idle();
    for (int k = 1; k <= 5; k++) begin
      jump = 1; jump_target = 32'(k) << 12; call = 1; step(); idle();
    end
    n_cmp++; if ({ras_full, pc} !== {1'b1, 32'h5000}) begin
      n_bad++; $display("FAIL ovf_full: got %b/%h want 1/5000", ras_full, pc); end
    for (int k = 0; k < 4; k++) begin
      ret = 1; step(); idle();
      n_cmp++; if (pc !== exp_ret[k]) begin
        n_bad++; $display("FAIL lifo%0d: got %h want %h", k, pc, exp_ret[k]); end
    end
    n_cmp++; if ({ras_empty, ras_full, ras_err} !== 3'b100) begin
      n_bad++; $display("FAIL ovf_end: got %b%b%b want 100", ras_empty, ras_full, ras_err); end
  endtask

  task automatic test_call_return_same();
    jump = 1; jump_target = 32'h300; call = 1; step(); idle();
    ret = 1; call = 1; step(); idle();
    n_cmp++; if ({pc, flush, ras_empty} !== {32'h1008, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL swap: got %h/%b%b want 1008/10", pc, flush, ras_empty); end
    stall = 1; jump = 1; jump_target = 32'h900; call = 1; step(); idle();
    n_cmp++; if (pc !== 32'h1008) begin n_bad++; $display("FAIL stall_call: got %h want 1008", pc); end
    exception = 1; jump = 1; jump_target = 32'h900; call = 1; step(); idle();
    n_cmp++; if (pc !== 32'h180) begin n_bad++; $display("FAIL exc_call: got %h want 180", pc); end
    ret = 1; step(); idle();
    n_cmp++; if ({pc, ras_empty} !== {32'h304, 1'b1}) begin
      n_bad++; $display("FAIL swap_top: got %h/%b want 304/1", pc, ras_empty); end
    n_cmp++; if (adv_cnt !== exp_cnt) begin
      n_bad++; $display("FAIL swap_cnt: got %0d want %0d", adv_cnt, exp_cnt); end
  endtask

  task automatic test_misaligned();
    jump_reg = 1; reg_target = 32'h203; step(); idle();
    n_cmp++; if ({pc, misaligned} !== {32'h200, 1'b1}) begin
      n_bad++; $display("FAIL mis_jr: got %h/%b want 200/1", pc, misaligned); end
    step();
    n_cmp++; if ({pc, misaligned} !== {32'h204, 1'b1}) begin
      n_bad++; $display("FAIL mis_sticky: got %h/%b want 204/1", pc, misaligned); end
    exception = 1; stall = 1; step(); idle();
    n_cmp++; if ({pc, flush} !== {32'h180, 1'b1}) begin
      n_bad++; $display("FAIL exc_stall: got %h/%b want 180/1", pc, flush); end
    n_cmp++; if (adv_cnt !== exp_cnt) begin
      n_bad++; $display("FAIL exc_cnt: got %0d want %0d", adv_cnt, exp_cnt); end
    reset = 1; step(); idle();
    n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL mis_clr: got %b want 0", misaligned); end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    step();
    n_cmp++; if ({pc, flush, misaligned} !== {32'h0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL wrap: got %h/%b%b want 0/00", pc, flush, misaligned); end
    step();
    reset = 1; exception = 1; step(); idle();
    n_cmp++; if ({pc, flush, adv_cnt} !== {32'h0, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL rst_exc: got %h/%b/%0d want 0/0/0", pc, flush, adv_cnt); end
  endtask

  task automatic test_priority();
    jump_reg = 1; reg_target = 32'h500; jump = 1; jump_target = 32'h600;
    branch_taken = 1; branch_offset = 32'd8; step(); idle();
    n_cmp++; if (pc !== 32'h500) begin n_bad++; $display("FAIL prio_jr: got %h want 500", pc); end
    jump = 1; jump_target = 32'h600; branch_taken = 1; branch_offset = 32'd8; step(); idle();
    n_cmp++; if (pc !== 32'h600) begin n_bad++; $display("FAIL prio_j: got %h want 600", pc); end
    branch_taken = 1; branch_offset = 32'd3; step(); idle();
    n_cmp++; if (pc !== 32'h610) begin n_bad++; $display("FAIL br_fwd: got %h want 610", pc); end
    n_cmp++; if (adv_cnt !== exp_cnt) begin
      n_bad++; $display("FAIL prio_cnt: got %0d want %0d", adv_cnt, exp_cnt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_branch();
    test_call_return();
    test_ras_overflow();
    test_call_return_same();
    test_misaligned();
    test_wrap();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
